// File: rtl/decoder_razor_ctrl.sv
// Iteration and Razor-recovery controller for the parallel turbo decoder array.
// Loads a frame, runs a programmed number of half-iterations and stalls the array on section errors.
module decoder_razor_ctrl #(
    parameter int NumSections   = 8,
    parameter int IterW         = 6,
    parameter int RecoverCycles = 1,
    parameter int MaxRetry      = 4
) (
    input  logic                   Clock,
    input  logic                   nReset,
    input  logic                   Start,
    input  logic [IterW-1:0]       NumIter,
    input  logic [NumSections-1:0] Error_Section,
    output logic                   Load,
    output logic                   Enable,
    output logic                   Replay,
    output logic                   Phase,
    output logic                   Busy,
    output logic                   Done,
    output logic                   Fail,
    output logic [7:0]             ErrorCount,
    output logic [2:0]             dbg_state
);

    // Handshake: Start is a level request accepted only in IDLE; Done is a
    // one-cycle completion strobe; Enable/Replay are same-cycle gates that
    // react to Error_Section combinationally while in RUN.

    localparam int CW = $clog2(MaxRetry + 1);
    localparam int RW = (RecoverCycles > 2) ? $clog2(RecoverCycles) : 1;
    localparam logic [CW-1:0] MaxRetryC = CW'(MaxRetry);
    localparam logic [RW-1:0] RecLoad   = RW'((RecoverCycles > 1) ? RecoverCycles - 2 : 0);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        RUN     = 3'd2,
        RECOVER = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t           state;
    logic [IterW-1:0] iter_target;
    logic [IterW-1:0] half_iter;
    logic [CW-1:0]    consec_err;
    logic [RW-1:0]    rec_cnt;
    logic             err_any;

    assign err_any   = |Error_Section;
    assign dbg_state = state;

    // The stall must take effect in the very cycle the error is flagged.
    assign Enable = (state == RUN) && !err_any;
    assign Replay = (state == RUN) && err_any;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state       <= IDLE;
            iter_target <= '0;
            half_iter   <= '0;
            consec_err  <= '0;
            rec_cnt     <= '0;
            Phase       <= 1'b0;
            Fail        <= 1'b0;
            ErrorCount  <= 8'd0;
            Load        <= 1'b0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
        end else begin
            Load <= 1'b0;
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        iter_target <= NumIter;
                        Fail        <= 1'b0;
                        ErrorCount  <= 8'd0;
                        half_iter   <= '0;
                        consec_err  <= '0;
                        Phase       <= 1'b0;
                        Load        <= 1'b1;
                        Busy        <= 1'b1;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    if (iter_target == '0) begin
                        Done  <= 1'b1;
                        Busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!err_any) begin
                        half_iter  <= half_iter + 1'b1;
                        Phase      <= ~Phase;
                        consec_err <= '0;
                        if (half_iter + 1'b1 == iter_target) begin
                            Done  <= 1'b1;
                            Busy  <= 1'b0;
                            state <= DONE;
                        end
                    end else begin
                        if (ErrorCount != 8'hFF) begin
                            ErrorCount <= ErrorCount + 8'd1;
                        end
                        consec_err <= consec_err + 1'b1;
                        if (consec_err + 1'b1 == MaxRetryC) begin
                            Fail  <= 1'b1;
                            Done  <= 1'b1;
                            Busy  <= 1'b0;
                            state <= DONE;
                        end else if (RecoverCycles > 1) begin
                            rec_cnt <= RecLoad;
                            state   <= RECOVER;
                        end
                    end
                end
                RECOVER: begin
                    // Errors seen while already stalled are not counted.
                    if (rec_cnt == '0) begin
                        state <= RUN;
                    end else begin
                        rec_cnt <= rec_cnt - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_razor_ctrl.sv
// Bench for decoder_razor_ctrl: two instances (RecoverCycles=1 and =3), directed frames,
// per-frame expected records queued by the driver and checked by a Done-triggered monitor.
module tb_decoder_razor_ctrl;

    localparam int W = 35;

    logic clk;
    logic n_reset;

    logic       start_a, start_b;
    logic [5:0] num_iter_a, num_iter_b;
    logic [7:0] err_a, err_b;

    logic       load_a, enable_a, replay_a, phase_a, busy_a, done_a, fail_a;
    logic [7:0] ecnt_a;
    logic [2:0] st_a;
    logic       load_b, enable_b, replay_b, phase_b, busy_b, done_b, fail_b;
    logic [7:0] ecnt_b;
    logic [2:0] st_b;

    decoder_razor_ctrl #(.NumSections(8), .IterW(6), .RecoverCycles(1), .MaxRetry(4)) dut_a (
        .Clock(clk), .nReset(n_reset), .Start(start_a), .NumIter(num_iter_a),
        .Error_Section(err_a), .Load(load_a), .Enable(enable_a), .Replay(replay_a),
        .Phase(phase_a), .Busy(busy_a), .Done(done_a), .Fail(fail_a),
        .ErrorCount(ecnt_a), .dbg_state(st_a)
    );

    decoder_razor_ctrl #(.NumSections(8), .IterW(6), .RecoverCycles(3), .MaxRetry(4)) dut_b (
        .Clock(clk), .nReset(n_reset), .Start(start_b), .NumIter(num_iter_b),
        .Error_Section(err_b), .Load(load_b), .Enable(enable_b), .Replay(replay_b),
        .Phase(phase_b), .Busy(busy_b), .Done(done_b), .Fail(fail_b),
        .ErrorCount(ecnt_b), .dbg_state(st_b)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;
    logic sel = 1'b0;

    logic       m_load, m_enable, m_replay, m_phase, m_busy, m_done, m_fail;
    logic [7:0] m_ecnt;
    assign m_load   = sel ? load_b   : load_a;
    assign m_enable = sel ? enable_b : enable_a;
    assign m_replay = sel ? replay_b : replay_a;
    assign m_phase  = sel ? phase_b  : phase_a;
    assign m_busy   = sel ? busy_b   : busy_a;
    assign m_done   = sel ? done_b   : done_a;
    assign m_fail   = sel ? fail_b   : fail_a;
    assign m_ecnt   = sel ? ecnt_b   : ecnt_a;

    logic [W-1:0] exp_q[$];

    function automatic logic [W-1:0] mk(input logic fail, input int ecnt, input int en,
                                        input int rep, input int lat, input logic ph);
        return {1'b0, fail, 8'(ecnt), 8'(en), 8'(rep), 8'(lat), ph};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // scoreboard monitor: one record per frame, compared on Done
    int   mon_lat, mon_en, mon_rep, frame_no;
    logic mon_ovl, in_frame;
    logic [W-1:0] act_rec, exp_rec;

    initial begin
        in_frame = 0; mon_lat = 0; mon_en = 0; mon_rep = 0; mon_ovl = 0; frame_no = 0;
    end

    always @(negedge clk) begin
        if (!n_reset) begin
            in_frame = 0; mon_lat = 0; mon_en = 0; mon_rep = 0; mon_ovl = 0;
        end else begin
            if (m_load) begin
                in_frame = 1; mon_lat = 0; mon_en = 0; mon_rep = 0; mon_ovl = 0;
            end else if (in_frame) begin
                mon_lat++;
            end
            if (m_enable) mon_en++;
            if (m_replay) mon_rep++;
            if ((m_enable && m_replay) || (m_done && m_busy)) mon_ovl = 1;
            if (m_done) begin
                act_rec = {mon_ovl, m_fail, m_ecnt, 8'(mon_en), 8'(mon_rep), 8'(mon_lat), m_phase};
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL frame_unexpected_done: got record %h expected none", act_rec);
                end else begin
                    exp_rec = exp_q.pop_front();
                    check($sformatf("frame_%0d", frame_no), act_rec, exp_rec);
                end
                frame_no++;
                in_frame = 0;
            end
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int n, input logic [W-1:0] exp);
        exp_q.push_back(exp);
        if (sel) begin start_b = 1'b1; num_iter_b = 6'(n); end
        else     begin start_a = 1'b1; num_iter_a = 6'(n); end
        tick(1);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic set_err(input logic [7:0] v);
        if (sel) err_b = v;
        else     err_a = v;
    endtask

    task automatic wait_idle();
        int budget;
        budget = 200;
        while ((m_busy || m_done) && budget > 0) begin
            tick(1);
            budget--;
        end
        if (budget == 0) begin
            checks++;
            failures++;
            $display("FAIL wait_idle_timeout: busy=%0b done=%0b expected idle", m_busy, m_done);
        end
        tick(1);
    endtask

    initial begin
        n_reset = 1'b0;
        start_a = 0; start_b = 0; num_iter_a = 0; num_iter_b = 0; err_a = 0; err_b = 0;
        tick(2);
        check("reset_a", W'({load_a, enable_a, replay_a, phase_a, busy_a, done_a, fail_a, ecnt_a}), '0);
        check("reset_b", W'({load_b, enable_b, replay_b, phase_b, busy_b, done_b, fail_b, ecnt_b}), '0);
        n_reset = 1'b1;
        tick(1);

        // clean frame, NumIter=5, with Enable/Phase trace in each RUN cycle
        start_frame(5, mk(0, 0, 5, 0, 6, 1));
        tick(1);
        for (int i = 1; i <= 5; i++) begin
            check($sformatf("run_c%0d_en_phase", i), W'({enable_a, phase_a}), W'({1'b1, 1'((i - 1) & 1)}));
            tick(1);
        end
        wait_idle();

        // NumIter=0
        start_frame(0, mk(0, 0, 0, 0, 1, 0));
        wait_idle();

        // NumIter=4, section 3 error during the 2nd Enable cycle
        start_frame(4, mk(0, 1, 4, 1, 6, 0));
        tick(2);
        set_err(8'b0000_1000);
        tick(1);
        set_err(8'h00);
        wait_idle();

        // NumIter=10, error held from the 3rd RUN cycle -> abort after 4 tries
        start_frame(10, mk(1, 4, 2, 4, 7, 0));
        tick(3);
        set_err(8'b0100_0000);
        wait_idle();
        set_err(8'h00);

        // Start re-pulsed while busy with a different NumIter is ignored
        start_frame(3, mk(0, 0, 3, 0, 4, 1));
        tick(2);
        start_a = 1'b1; num_iter_a = 6'd9;
        tick(1);
        start_a = 1'b0;
        wait_idle();

        // reset mid-RUN: outputs drop at once, no Done for the aborted frame
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        num_iter_a = 6'd6;
        tick(1);
        start_a = 1'b0;
        tick(4);
        check("busy_before_reset", W'(busy_a), W'(1'b1));
        n_reset = 1'b0;
        #1;
        check("mid_reset_outputs", W'({load_a, enable_a, replay_a, phase_a, busy_a, done_a, fail_a, ecnt_a}), '0);
        tick(1);
        n_reset = 1'b1;
        tick(1);
        start_frame(2, mk(0, 0, 2, 0, 3, 0));
        wait_idle();

        // RecoverCycles=3 instance: one error, held through the recovery window
        sel = 1'b1;
        tick(1);
        start_frame(4, mk(0, 1, 4, 1, 8, 0));
        tick(2);
        set_err(8'b0000_0001);
        tick(3);
        set_err(8'h00);
        wait_idle();

        check("queue_drained", W'(exp_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
